// File: rtl/i2c_frame_tx.sv
// Serialises one payload byte into an 11-bit frame: start, 8 data bits MSB first, pad/parity, stop.
// Defining I2C_TX_PARITY_EN makes frame[1] the even parity of the byte; otherwise frame[1] is a constant 1.
module i2c_frame_tx #(
    parameter int HALF_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       SDA_OUT,
    output logic       SCL_OUT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

`ifdef I2C_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'd10;

    function automatic logic [10:0] build_frame(input logic [7:0] data);
        logic pad_bit;
        pad_bit = PARITY_EN ? (^data) : 1'b1;
        return {1'b0, data, pad_bit, 1'b1};
    endfunction

    state_t      state_q;
    logic [10:0] shreg_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic        high_q;
    logic        tx_ready_q;
    logic        sda_q;
    logic        scl_q;
    logic        busy_q;
    logic        done_q;
    logic        accept;
    logic [10:0] frame_d;

    assign accept   = TX_VALID & tx_ready_q;
    assign frame_d  = build_frame(TX_DATA);

    assign TX_READY = tx_ready_q;
    assign SDA_OUT  = sda_q;
    assign SCL_OUT  = scl_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    // Frame sequencer; shreg_q[10] is always the bit currently on SDA, so each
    // new bit comes from shreg_q[9] as the register rotates.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            shreg_q    <= 11'd0;
            div_q      <= 8'd0;
            bit_q      <= 4'd0;
            high_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q    <= SHIFT;
                        shreg_q    <= frame_d;
                        div_q      <= 8'd0;
                        bit_q      <= 4'd0;
                        high_q     <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        sda_q      <= frame_d[10];
                        scl_q      <= 1'b0;
                    end else begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        sda_q      <= 1'b1;
                        scl_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= 8'd0;
                        if (!high_q) begin
                            high_q <= 1'b1;
                            scl_q  <= 1'b1;
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= FINISH;
                            high_q  <= 1'b0;
                            sda_q   <= 1'b1;
                            scl_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            high_q  <= 1'b0;
                            scl_q   <= 1'b0;
                            sda_q   <= shreg_q[9];
                            shreg_q <= {shreg_q[9:0], shreg_q[10]};
                        end
                    end
                end
                FINISH: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                    sda_q      <= 1'b1;
                    scl_q      <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                    sda_q      <= 1'b1;
                    scl_q      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Directed bench for i2c_frame_tx at HALF_DIV=2; expected frames are hand-computed
// for both the pad-bit build and the I2C_TX_PARITY_EN build.
module tb_i2c_frame_tx;

    localparam int HD = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       TX_READY;
    logic       SDA_OUT;
    logic       SCL_OUT;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    i2c_frame_tx #(.HALF_DIV(HD)) dut (
        .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .SDA_OUT(SDA_OUT), .SCL_OUT(SCL_OUT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_pad;
        logic [10:0] exp_par;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pick(input logic [10:0] pad_v, input logic [10:0] par_v);
`ifdef I2C_TX_PARITY_EN
        return par_v;
`else
        return pad_v;
`endif
    endfunction

    // Offer a byte at a negedge; it is accepted on the following posedge.
    task automatic start(input logic [7:0] d);
        chk("ready_before_start", {31'd0, TX_READY}, 32'd1);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        @(posedge CLK);
        #1 TX_VALID = 1'b0;
    endtask

    // Called just after the accepting posedge; returns at the negedge of the IDLE cycle after FINISH.
    task automatic capture(input logic [10:0] exp, input string name, input bit inject);
        logic [10:0] bits;
        int          nbits;
        int          done_cyc;
        bit          prev_scl, prev_sda, hold_ok, stable_ok, first_ok, finish_ok;
        bits = 11'd0; nbits = 0; done_cyc = -1;
        prev_scl = 1'b1; prev_sda = 1'b1;
        hold_ok = 1'b1; stable_ok = 1'b1; first_ok = 1'b0; finish_ok = 1'b0;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            if (inject && cyc == 20) begin
                TX_DATA  = 8'h55;
                TX_VALID = 1'b1;
            end
            if (inject && cyc == 24) TX_VALID = 1'b0;
            if (cyc == 1) first_ok = (SDA_OUT === exp[10]) && (SCL_OUT === 1'b0);
            if (DONE === 1'b1) begin
                done_cyc  = cyc;
                finish_ok = (SDA_OUT === 1'b1) && (SCL_OUT === 1'b1) && (BUSY === 1'b1);
            end else begin
                if (TX_READY !== 1'b0 || BUSY !== 1'b1) hold_ok = 1'b0;
                if (prev_scl && SCL_OUT && (SDA_OUT !== prev_sda)) stable_ok = 1'b0;
                if (!prev_scl && SCL_OUT) begin
                    if (nbits < 11) bits[10 - nbits] = SDA_OUT;
                    nbits++;
                end
            end
            prev_scl = SCL_OUT;
            prev_sda = SDA_OUT;
        end
        chk({name, "_bits"}, {21'd0, bits}, {21'd0, exp});
        chk({name, "_nbits"}, nbits, 32'd11);
        chk({name, "_done_cycle"}, done_cyc, 22 * HD + 1);
        chk({name, "_first_bit"}, {31'd0, first_ok}, 32'd1);
        chk({name, "_ready_busy_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({name, "_sda_stable"}, {31'd0, stable_ok}, 32'd1);
        chk({name, "_finish_lines"}, {31'd0, finish_ok}, 32'd1);
        @(negedge CLK);
        chk({name, "_done_one_cycle"}, {31'd0, DONE}, 32'd0);
        chk({name, "_idle_ready"}, {31'd0, TX_READY}, 32'd1);
        chk({name, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{8'hA5, 11'b0_10100101_1_1, 11'b0_10100101_0_1};
        vecs[1] = '{8'h01, 11'b0_00000001_1_1, 11'b0_00000001_1_1};
        vecs[2] = '{8'h80, 11'b0_10000000_1_1, 11'b0_10000000_1_1};
        vecs[3] = '{8'h07, 11'b0_00000111_1_1, 11'b0_00000111_1_1};

        // Reset held for three edges
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_sda", {31'd0, SDA_OUT}, 32'd1);
        chk("rst_scl", {31'd0, SCL_OUT}, 32'd1);
        chk("rst_ready", {31'd0, TX_READY}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);

        // Reset wins over a simultaneous offer
        TX_VALID = 1'b1;
        @(negedge CLK);
        chk("rst_prio_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_prio_sda", {31'd0, SDA_OUT}, 32'd1);
        TX_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", {31'd0, BUSY}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            start(vecs[i].data);
            capture(pick(vecs[i].exp_pad, vecs[i].exp_par), $sformatf("vec%0d", i), 1'b0);
        end

        // 0x55 offered mid-frame must be ignored
        start(8'hAA);
        capture(pick(11'b0_10101010_1_1, 11'b0_10101010_0_1), "ignore_busy", 1'b1);
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || DONE !== 1'b0) seen++;
        end
        chk("ignore_no_extra_frame", seen, 32'd0);

        // Back-to-back with TX_VALID held; data changes during the first frame
        TX_DATA  = 8'hFF;
        TX_VALID = 1'b1;
        @(posedge CLK);
        #1 TX_DATA = 8'h00;
        capture(pick(11'b0_11111111_1_1, 11'b0_11111111_0_1), "b2b_ff", 1'b0);
        @(posedge CLK);
        #1 TX_VALID = 1'b0;
        capture(pick(11'b0_00000000_1_1, 11'b0_00000000_0_1), "b2b_00", 1'b0);
        @(negedge CLK);
        chk("b2b_no_third", {31'd0, BUSY}, 32'd0);

        // Abort during bit 5 (cycles 21..24 after acceptance)
        start(8'hA5);
        repeat (22) @(negedge CLK);
        chk("abort_busy_before", {31'd0, BUSY}, 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_sda", {31'd0, SDA_OUT}, 32'd1);
        chk("abort_scl", {31'd0, SCL_OUT}, 32'd1);
        chk("abort_ready", {31'd0, TX_READY}, 32'd1);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_done", {31'd0, DONE}, 32'd0);
        RST = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE !== 1'b0) seen++;
        end
        chk("abort_no_done", seen, 32'd0);
        start(8'h3C);
        capture(pick(11'b0_00111100_1_1, 11'b0_00111100_0_1), "after_abort", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
